// File: rtl/isa_bus_pkg.sv
// Purpose : shared ISA bus types: FSM states, encoded chip-select codes, default timing.
// Latency : n/a (types and constants only).
// Backpr. : n/a. The ISA listener uses the same encoded chip-select values.
package isa_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_BALE = 3'd2,
    ST_CMD  = 3'd3,
    ST_WAIT = 3'd4,
    ST_HOLD = 3'd5,
    ST_RESP = 3'd6
  } state_t;

  // Encoded chip select. Codes 5..7 select nothing.
  typedef logic [2:0] enc_cs_t;
  localparam enc_cs_t CS_NONE = 3'd0;
  localparam enc_cs_t CS_0    = 3'd1;
  localparam enc_cs_t CS_1    = 3'd2;
  localparam enc_cs_t CS_2    = 3'd3;
  localparam enc_cs_t CS_3    = 3'd4;

  // Default timing, in Clock50MHz cycles.
  localparam int T_ADDR_DEF  = 2;
  localparam int T_BALE_DEF  = 3;
  localparam int T_CMD_DEF   = 10;
  localparam int T_HOLD_DEF  = 2;
  localparam int TIMEOUT_DEF = 1000;

  // The state down-counter is wide enough for TIMEOUT up to 65536.
  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;

  // A phase lasting 'cycles' cycles loads cycles-1 and leaves on zero.
  function automatic cnt_t cnt_load(input int cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/isa_cycle_generator_if.sv
// Purpose : host command/response and ISA bus signals of the cycle generator.
// Latency : n/a (wiring only).
// Backpr. : CmdValid/CmdReady handshake; IOCHRDY low stretches the bus cycle.
// master = the cycle generator, slave = host plus bus target (or a bench).
// SDIn is the resolved SD bus value seen by the initiator during reads.
interface isa_cycle_generator_if;
  logic                 CmdValid;
  logic                 CmdReady;
  logic [19:0]          CmdAddr;
  logic [15:0]          CmdData;
  logic                 CmdIsIO;
  logic                 CmdIsWrite;
  logic                 CmdIs16;
  isa_bus_pkg::enc_cs_t CmdCs;
  logic                 RspValid;
  logic [15:0]          RspData;
  logic                 RspTimeout;
  logic [19:0]          SA;
  logic [15:0]          SD;
  logic                 SDOe;
  logic [15:0]          SDIn;
  logic                 SBHE;
  logic                 AEN;
  logic                 BALE;
  logic                 nIOR;
  logic                 nIOW;
  logic                 nMEMR;
  logic                 nMEMW;
  logic [3:0]           nCS;
  logic                 IOCHRDY;

  modport master (
    input  CmdValid, CmdAddr, CmdData, CmdIsIO, CmdIsWrite, CmdIs16, CmdCs,
    input  SDIn, IOCHRDY,
    output CmdReady, RspValid, RspData, RspTimeout,
    output SA, SD, SDOe, SBHE, AEN, BALE, nIOR, nIOW, nMEMR, nMEMW, nCS
  );

  modport slave (
    output CmdValid, CmdAddr, CmdData, CmdIsIO, CmdIsWrite, CmdIs16, CmdCs,
    output SDIn, IOCHRDY,
    input  CmdReady, RspValid, RspData, RspTimeout,
    input  SA, SD, SDOe, SBHE, AEN, BALE, nIOR, nIOW, nMEMR, nMEMW, nCS
  );
endinterface

// File: rtl/isa_cs_decode.sv
// Purpose : encoded chip select to one-cold nCS[3:0]; unused codes deselect all.
// Latency : combinational.
// Backpr. : none.
// Ports   : i_cs (encoded CS), o_ncs (active-low chip selects).
module isa_cs_decode
  import isa_bus_pkg::*;
(
  input  enc_cs_t    i_cs,
  output logic [3:0] o_ncs
);

  always_comb begin
    o_ncs = 4'b1111;
    case (i_cs)
      CS_0:    o_ncs = 4'b1110;
      CS_1:    o_ncs = 4'b1101;
      CS_2:    o_ncs = 4'b1011;
      CS_3:    o_ncs = 4'b0111;
      default: o_ncs = 4'b1111;
    endcase
  end

endmodule

// File: rtl/isa_cycle_generator.sv
// Purpose : ISA bus initiator; one host command becomes one I/O or memory read/write cycle.
// Latency : T_ADDR+T_BALE+T_CMD+W+T_HOLD+1 cycles from handshake to RspValid (W = wait cycles).
// Backpr. : CmdReady only in IDLE (no queue); IOCHRDY low extends the strobe up to TIMEOUT cycles.
// Ports   : Clock50MHz, Reset (async, active-high), bus (master modport: host command/response,
//           SA/SD/SDOe/SBHE/AEN/BALE, four command strobes, nCS, IOCHRDY and read data SDIn).
module isa_cycle_generator
  import isa_bus_pkg::*;
#(
  parameter int T_ADDR  = T_ADDR_DEF,
  parameter int T_BALE  = T_BALE_DEF,
  parameter int T_CMD   = T_CMD_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   Clock50MHz,
  input  logic                   Reset,
  isa_cycle_generator_if.master  bus
);

  state_t      r_state;
  cnt_t        r_cnt;
  logic        r_is_io;
  logic        r_is_wr;
  logic        r_is16;
  logic        r_timeout;
  logic [15:0] r_rd_dat;
  logic        r_rdy_meta;
  logic        r_rdy_sync;

  logic        r_cmd_rdy;
  logic        r_rsp_vld;
  logic [15:0] r_rsp_dat;
  logic        r_rsp_to;
  logic [19:0] r_sa;
  logic [15:0] r_sd;
  logic        r_sdoe;
  logic        r_sbhe;
  logic        r_aen;
  logic        r_bale;
  logic        r_nior;
  logic        r_niow;
  logic        r_nmemr;
  logic        r_nmemw;
  logic [3:0]  r_ncs;

  logic [3:0]  w_ncs;
  logic [15:0] w_rd_sample;

  isa_cs_decode u_cs_decode (
    .i_cs  (bus.CmdCs),
    .o_ncs (w_ncs)
  );

  // 8-bit reads only see the low data lane.
  assign w_rd_sample = r_is16 ? bus.SDIn : {8'h00, bus.SDIn[7:0]};

  // IOCHRDY comes from the target's clock domain; resets to "ready".
  always_ff @(posedge Clock50MHz or posedge Reset) begin
    if (Reset) begin
      r_rdy_meta <= 1'b1;
      r_rdy_sync <= 1'b1;
    end else begin
      r_rdy_meta <= bus.IOCHRDY;
      r_rdy_sync <= r_rdy_meta;
    end
  end

  // Every output is a flop updated on the state transition that needs it,
  // so strobes and BALE cannot glitch and only one strobe is ever low.
  always_ff @(posedge Clock50MHz or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_is_io   <= 1'b0;
      r_is_wr   <= 1'b0;
      r_is16    <= 1'b0;
      r_timeout <= 1'b0;
      r_rd_dat  <= 16'h0000;
      r_cmd_rdy <= 1'b1;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= 16'h0000;
      r_rsp_to  <= 1'b0;
      r_sa      <= 20'h00000;
      r_sd      <= 16'h0000;
      r_sdoe    <= 1'b0;
      r_sbhe    <= 1'b1;
      r_aen     <= 1'b1;
      r_bale    <= 1'b0;
      r_nior    <= 1'b1;
      r_niow    <= 1'b1;
      r_nmemr   <= 1'b1;
      r_nmemw   <= 1'b1;
      r_ncs     <= 4'b1111;
    end else begin
      r_rsp_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.CmdValid) begin
            r_is_io   <= bus.CmdIsIO;
            r_is_wr   <= bus.CmdIsWrite;
            r_is16    <= bus.CmdIs16;
            r_timeout <= 1'b0;
            r_cmd_rdy <= 1'b0;
            r_sa      <= bus.CmdAddr;
            r_sd      <= bus.CmdIsWrite ? bus.CmdData : 16'h0000;
            r_sdoe    <= bus.CmdIsWrite;
            r_sbhe    <= ~bus.CmdIs16;
            r_aen     <= 1'b0;
            r_ncs     <= w_ncs;
            r_cnt     <= cnt_load(T_ADDR);
            r_state   <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (r_cnt == '0) begin
            r_bale  <= 1'b1;
            r_cnt   <= cnt_load(T_BALE);
            r_state <= ST_BALE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_BALE: begin
          if (r_cnt == '0) begin
            r_bale  <= 1'b0;
            r_nior  <= ~( r_is_io & ~r_is_wr);
            r_niow  <= ~( r_is_io &  r_is_wr);
            r_nmemr <= ~(~r_is_io & ~r_is_wr);
            r_nmemw <= ~(~r_is_io &  r_is_wr);
            r_cnt   <= cnt_load(T_CMD);
            r_state <= ST_CMD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_CMD: begin
          if (r_cnt == '0) begin
            if (r_rdy_sync) begin
              // Final strobe-low cycle: capture read data and release.
              r_rd_dat <= r_is_wr ? 16'h0000 : w_rd_sample;
              r_nior   <= 1'b1;
              r_niow   <= 1'b1;
              r_nmemr  <= 1'b1;
              r_nmemw  <= 1'b1;
              r_cnt    <= cnt_load(T_HOLD);
              r_state  <= ST_HOLD;
            end else begin
              r_cnt   <= cnt_load(TIMEOUT);
              r_state <= ST_WAIT;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_WAIT: begin
          if (r_rdy_sync || (r_cnt == '0)) begin
            // A timed-out read returns zero rather than whatever floats on SD.
            r_timeout <= ~r_rdy_sync;
            r_rd_dat  <= (r_is_wr || !r_rdy_sync) ? 16'h0000 : w_rd_sample;
            r_nior    <= 1'b1;
            r_niow    <= 1'b1;
            r_nmemr   <= 1'b1;
            r_nmemw   <= 1'b1;
            r_cnt     <= cnt_load(T_HOLD);
            r_state   <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_rsp_vld <= 1'b1;
            r_rsp_dat <= r_rd_dat;
            r_rsp_to  <= r_timeout;
            r_sa      <= 20'h00000;
            r_sd      <= 16'h0000;
            r_sdoe    <= 1'b0;
            r_sbhe    <= 1'b1;
            r_aen     <= 1'b1;
            r_ncs     <= 4'b1111;
            r_cnt     <= '0;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_RESP: begin
          r_rsp_dat <= 16'h0000;
          r_rsp_to  <= 1'b0;
          r_timeout <= 1'b0;
          r_cmd_rdy <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_cmd_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign bus.CmdReady   = r_cmd_rdy;
  assign bus.RspValid   = r_rsp_vld;
  assign bus.RspData    = r_rsp_dat;
  assign bus.RspTimeout = r_rsp_to;
  assign bus.SA         = r_sa;
  assign bus.SD         = r_sd;
  assign bus.SDOe       = r_sdoe;
  assign bus.SBHE       = r_sbhe;
  assign bus.AEN        = r_aen;
  assign bus.BALE       = r_bale;
  assign bus.nIOR       = r_nior;
  assign bus.nIOW       = r_niow;
  assign bus.nMEMR      = r_nmemr;
  assign bus.nMEMW      = r_nmemw;
  assign bus.nCS        = r_ncs;

endmodule
